// File: rtl/hazard_unit_mc.sv
// Hazard unit for a five-stage pipeline: operand forwarding, load-use stall, control-flow flush
// and a stall sequencer for a multi-cycle mul/div unit sitting in Execute.
module hazard_unit_mc #(
  parameter int unsigned AW     = 5,
  parameter int unsigned MD_LAT = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] rs1_d_i,
  input  logic [AW-1:0] rs2_d_i,
  input  logic [AW-1:0] rs1_e_i,
  input  logic [AW-1:0] rs2_e_i,
  input  logic [AW-1:0] rd_e_i,
  input  logic [AW-1:0] rd_m_i,
  input  logic [AW-1:0] rd_w_i,
  input  logic          regwrt_m_i,
  input  logic          regwrt_w_i,
  input  logic [1:0]    rsltsrc_e_i,
  input  logic [1:0]    pcsrc_e_i,
  input  logic          md_op_e_i,
  output logic [1:0]    fwd_a_e_o,
  output logic [1:0]    fwd_b_e_o,
  output logic          stall_f_o,
  output logic          stall_d_o,
  output logic          stall_e_o,
  output logic          flush_d_o,
  output logic          flush_e_o,
  output logic          flush_m_o,
  output logic          md_start_o,
  output logic          md_busy_o
);

  typedef enum logic [1:0] {
    StIdle,
    StMdBusy,
    StMdDone
  } state_e;

  localparam logic [4:0] CntInit = 5'(MD_LAT - 1);

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;

  logic       md_stall;
  logic       md_start;
  logic       md_busy;
  logic       lu;
  logic       cf;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  // Memory stage holds the younger result, so it wins over Writeback.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (regwrt_m_i && (rd_m_i != '0) && (rd_m_i == rs1_e_i)) begin
      fwd_a = 2'b10;
    end else if (regwrt_w_i && (rd_w_i != '0) && (rd_w_i == rs1_e_i)) begin
      fwd_a = 2'b01;
    end
    if (regwrt_m_i && (rd_m_i != '0) && (rd_m_i == rs2_e_i)) begin
      fwd_b = 2'b10;
    end else if (regwrt_w_i && (rd_w_i != '0) && (rd_w_i == rs2_e_i)) begin
      fwd_b = 2'b01;
    end
  end

  assign lu = (rsltsrc_e_i == 2'b01) && (rd_e_i != '0) &&
              ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));
  assign cf = (pcsrc_e_i == 2'b01) || (pcsrc_e_i == 2'b10);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_stall = 1'b0;
    md_start = 1'b0;
    md_busy  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (md_op_e_i) begin
          md_start = 1'b1;
          md_stall = 1'b1;
          cnt_d    = CntInit;
          state_d  = StMdBusy;
        end
      end
      StMdBusy: begin
        md_stall = 1'b1;
        md_busy  = 1'b1;
        if (cnt_q == 5'd0) begin
          state_d = StMdDone;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      // The finished instruction is still in Execute here, so md_op_e_i is not a new request.
      StMdDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The mul/div sequencer masks both hazard sources; a control flush beats a load-use stall.
  always_comb begin
    fwd_a_e_o  = 2'b00;
    fwd_b_e_o  = 2'b00;
    stall_f_o  = 1'b0;
    stall_d_o  = 1'b0;
    stall_e_o  = 1'b0;
    flush_d_o  = 1'b0;
    flush_e_o  = 1'b0;
    flush_m_o  = 1'b0;
    md_start_o = 1'b0;
    md_busy_o  = 1'b0;
    if (rst_i) begin
      fwd_a_e_o = fwd_a;
      fwd_b_e_o = fwd_b;
      if (md_stall) begin
        stall_f_o  = 1'b1;
        stall_d_o  = 1'b1;
        stall_e_o  = 1'b1;
        flush_m_o  = 1'b1;
        md_start_o = md_start;
        md_busy_o  = md_busy;
      end else if (cf) begin
        flush_d_o = 1'b1;
        flush_e_o = 1'b1;
      end else if (lu) begin
        stall_f_o = 1'b1;
        stall_d_o = 1'b1;
        flush_e_o = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc: two instances (MD_LAT=4 and MD_LAT=1) share one stimulus.
module tb_hazard_unit_mc;

  logic       clk;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       regwrt_m, regwrt_w;
  logic [1:0] rsltsrc_e, pcsrc_e;
  logic       md_op_e;

  logic [1:0] fwd_a4, fwd_b4, fwd_a1, fwd_b1;
  logic       sf4, sd4, se4, fd4, fe4, fm4, ms4, mb4;
  logic       sf1, sd1, se1, fd1, fe1, fm1, ms1, mb1;
  logic [7:0] ctl4, ctl1;

  int n_vec = 0;
  int n_err = 0;

  // Control byte: {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, md_start, md_busy}
  localparam logic [7:0] None   = 8'h00;
  localparam logic [7:0] LdUse  = 8'hC8;
  localparam logic [7:0] CtlFl  = 8'h18;
  localparam logic [7:0] Launch = 8'hE6;
  localparam logic [7:0] Busy   = 8'hE5;

  assign ctl4 = {sf4, sd4, se4, fd4, fe4, fm4, ms4, mb4};
  assign ctl1 = {sf1, sd1, se1, fd1, fe1, fm1, ms1, mb1};

  hazard_unit_mc #(.AW(5), .MD_LAT(4)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .rs1_d_i(rs1_d), .rs2_d_i(rs2_d), .rs1_e_i(rs1_e), .rs2_e_i(rs2_e), .rd_e_i(rd_e),
    .rd_m_i(rd_m), .rd_w_i(rd_w), .regwrt_m_i(regwrt_m), .regwrt_w_i(regwrt_w),
    .rsltsrc_e_i(rsltsrc_e), .pcsrc_e_i(pcsrc_e), .md_op_e_i(md_op_e),
    .fwd_a_e_o(fwd_a4), .fwd_b_e_o(fwd_b4),
    .stall_f_o(sf4), .stall_d_o(sd4), .stall_e_o(se4),
    .flush_d_o(fd4), .flush_e_o(fe4), .flush_m_o(fm4),
    .md_start_o(ms4), .md_busy_o(mb4)
  );

  hazard_unit_mc #(.AW(5), .MD_LAT(1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .rs1_d_i(rs1_d), .rs2_d_i(rs2_d), .rs1_e_i(rs1_e), .rs2_e_i(rs2_e), .rd_e_i(rd_e),
    .rd_m_i(rd_m), .rd_w_i(rd_w), .regwrt_m_i(regwrt_m), .regwrt_w_i(regwrt_w),
    .rsltsrc_e_i(rsltsrc_e), .pcsrc_e_i(pcsrc_e), .md_op_e_i(md_op_e),
    .fwd_a_e_o(fwd_a1), .fwd_b_e_o(fwd_b1),
    .stall_f_o(sf1), .stall_d_o(sd1), .stall_e_o(se1),
    .flush_d_o(fd1), .flush_e_o(fe1), .flush_m_o(fm1),
    .md_start_o(ms1), .md_busy_o(mb1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    rs1_d = 5'd0; rs2_d = 5'd0; rs1_e = 5'd5; rs2_e = 5'd5; rd_e = 5'd7;
    rd_m = 5'd5; rd_w = 5'd5; regwrt_m = 1'b1; regwrt_w = 1'b1;
    rsltsrc_e = 2'b01; pcsrc_e = 2'b00; md_op_e = 1'b1;
    rs2_d = 5'd7;
    #2;
    // Everything that would fire is present, yet reset forces all outputs low.
    chk("rst_ctl4", ctl4, None);
    chk("rst_ctl1", ctl1, None);
    chk("rst_fwd4", {4'd0, fwd_a4, fwd_b4}, 8'h00);
    chk("rst_fwd1", {4'd0, fwd_a1, fwd_b1}, 8'h00);
    tick();
    tick();
    rst = 1'b1;
    md_op_e = 1'b0; rsltsrc_e = 2'b00; rs2_d = 5'd0;
    #1;

    // Forwarding
    chk("fwd_a_mem", {6'd0, fwd_a4}, 8'h02);
    chk("fwd_b_mem", {6'd0, fwd_b4}, 8'h02);
    rd_m = 5'd0; #1;
    chk("fwd_a_wb", {6'd0, fwd_a4}, 8'h01);
    rd_m = 5'd5; regwrt_m = 1'b0; #1;
    chk("fwd_a_wb_nowr_m", {6'd0, fwd_a4}, 8'h01);
    regwrt_w = 1'b0; #1;
    chk("fwd_a_none_nowr", {6'd0, fwd_a4}, 8'h00);
    regwrt_m = 1'b1; regwrt_w = 1'b1; rd_m = 5'd0; rd_w = 5'd0; rs1_e = 5'd0; #1;
    chk("fwd_a_x0", {6'd0, fwd_a4}, 8'h00);
    rs2_e = 5'd3; rd_m = 5'd3; rd_w = 5'd3; #1;
    chk("fwd_b_mem_r3", {6'd0, fwd_b4}, 8'h02);
    chk("fwd_a_r3_nomatch", {6'd0, fwd_a4}, 8'h00);
    rd_m = 5'd0; rd_w = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0;
    chk("idle_ctl4", ctl4, None);

    // Load-use
    rsltsrc_e = 2'b01; rd_e = 5'd7; rs2_d = 5'd7; #1;
    chk("lu_rs2", ctl4, LdUse);
    chk("lu_rs2_d1", ctl1, LdUse);
    tick();
    rsltsrc_e = 2'b00; #1;
    chk("lu_cleared", ctl4, None);
    rsltsrc_e = 2'b01; rs2_d = 5'd0; rs1_d = 5'd7; #1;
    chk("lu_rs1", ctl4, LdUse);
    rd_e = 5'd0; rs1_d = 5'd0; #1;
    chk("lu_rd_x0", ctl4, None);

    // Control flush and its priority over load-use
    rd_e = 5'd7; rs2_d = 5'd7; pcsrc_e = 2'b10; #1;
    chk("cf_jump_over_lu", ctl4, CtlFl);
    pcsrc_e = 2'b01; #1;
    chk("cf_branch", ctl4, CtlFl);
    pcsrc_e = 2'b11; #1;
    chk("pc_rsvd_lu_only", ctl4, LdUse);
    rsltsrc_e = 2'b00; #1;
    chk("pc_rsvd_none", ctl4, None);
    pcsrc_e = 2'b00; rd_e = 5'd0; rs2_d = 5'd0;

    // Mul/div: T0 launch
    tick();
    md_op_e = 1'b1; #1;
    chk("md_t0_lat4", ctl4, Launch);
    chk("md_t0_lat1", ctl1, Launch);
    tick(); // T1, with a load-use condition that must be masked
    rsltsrc_e = 2'b01; rd_e = 5'd7; rs2_d = 5'd7; #1;
    chk("md_t1_lat4_mask_lu", ctl4, Busy);
    chk("md_t1_lat1_mask_lu", ctl1, Busy);
    tick(); // T2: MD_LAT=1 reaches MD_DONE where hazards are live again
    rsltsrc_e = 2'b00; rd_e = 5'd0; rs2_d = 5'd0; pcsrc_e = 2'b10; #1;
    chk("md_t2_lat4_mask_cf", ctl4, Busy);
    chk("md_t2_lat1_done_cf", ctl1, CtlFl);
    tick(); // T3: MD_LAT=1 back in IDLE with md_op held, so it relaunches
    pcsrc_e = 2'b00; #1;
    chk("md_t3_lat4", ctl4, Busy);
    chk("md_t3_lat1_relaunch", ctl1, Launch);
    tick(); // T4
    chk("md_t4_lat4", ctl4, Busy);
    chk("md_t4_lat1", ctl1, Busy);
    tick(); // T5: MD_DONE ignores the held md_op
    chk("md_t5_lat4_done", ctl4, None);
    chk("md_t5_lat1_done", ctl1, None);
    tick(); // T6: IDLE, held md_op starts a new operation
    chk("md_t6_lat4_relaunch", ctl4, Launch);
    chk("md_t6_lat1_relaunch", ctl1, Launch);
    tick(); // T7 = second op's T1
    chk("md2_t1_lat4", ctl4, Busy);
    tick(); // T8 = second op's T2; abort with reset
    rs1_e = 5'd5; rd_m = 5'd5; #1;
    chk("md2_t2_lat4", ctl4, Busy);
    chk("md2_fwd_live_busy", {6'd0, fwd_a4}, 8'h02);
    rst = 1'b0; #1;
    chk("abort_ctl4_immediate", ctl4, None);
    chk("abort_fwd4_immediate", {4'd0, fwd_a4, fwd_b4}, 8'h00);
    tick();
    rst = 1'b1; md_op_e = 1'b0; rs1_e = 5'd0; rd_m = 5'd0; #1;
    chk("post_rst_ctl4", ctl4, None);
    chk("post_rst_ctl1", ctl1, None);
    tick();
    chk("post_rst_ctl4_next", ctl4, None);
    md_op_e = 1'b1; #1;
    chk("post_rst_launch", ctl4, Launch);
    tick();
    chk("post_rst_busy", ctl4, Busy);
    md_op_e = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
HAZARD_UNIT_MC -- requirements
Module: hazard_unit_mc

Interface
REQ-001: Parameter AW, default 5, sets the register-address width.
REQ-002: Parameter MD_LAT, default 4, legal range 1..31, sets the number of busy cycles of the multi-cycle mul/div unit.
REQ-003: Port clk_i  in  1  is the single clock; all state updates on its rising edge.
REQ-004: Port rst_i  in  1  is the reset: synchronous, active-low.
REQ-005: Ports rs1_d_i, rs2_d_i  in  AW  are the source registers of the instruction in Decode.
REQ-006: Ports rs1_e_i, rs2_e_i, rd_e_i  in  AW  are the sources and destination of the instruction in Execute.
REQ-007: Ports rd_m_i, rd_w_i  in  AW  are the destinations in Memory and Writeback.
REQ-008: Ports regwrt_m_i, regwrt_w_i  in  1  are the register-write enables of Memory and Writeback.
REQ-009: Port rsltsrc_e_i  in  2  is the Execute result source; 2'b01 marks a load.
REQ-010: Port pcsrc_e_i  in  2  is the Execute PC source: 00 sequential, 01 branch taken, 10 jump/JALR, 11 reserved (treated as 00).
REQ-011: Port md_op_e_i  in  1  flags a mul/div instruction in Execute.
REQ-012: Ports fwd_a_e_o, fwd_b_e_o  out  2  are the operand forward selects: 00 regfile, 01 Writeback, 10 Memory.
REQ-013: Ports stall_f_o, stall_d_o, stall_e_o  out  1  hold the Fetch, Decode and Execute pipeline registers.
REQ-014: Ports flush_d_o, flush_e_o, flush_m_o  out  1  insert bubbles into the Decode, Execute and Memory registers.
REQ-015: Ports md_start_o, md_busy_o  out  1  are the mul/div launch pulse and the busy indicator.

Function
REQ-016: fwd_a_e_o shall be 10 if regwrt_m_i & rd_m_i!=0 & rd_m_i==rs1_e_i; else 01 if regwrt_w_i & rd_w_i!=0 & rd_w_i==rs1_e_i; else 00.
REQ-017: fwd_b_e_o shall use the same rule as REQ-016 with rs2_e_i.
REQ-018: Forwarding shall be combinational and active in every FSM state.
REQ-019: Load-use (lu) = rsltsrc_e_i==01 & rd_e_i!=0 & (rd_e_i==rs1_d_i | rd_e_i==rs2_d_i).
REQ-020: When lu is asserted, the block shall assert stall_f_o, stall_d_o and flush_e_o for that cycle.
REQ-021: Control flush (cf) = pcsrc_e_i in {01,10}; when cf is asserted, the block shall assert flush_d_o and flush_e_o.
REQ-022: cf shall take priority over lu: with both asserted, stall_f_o=stall_d_o=0 and flush_d_o=flush_e_o=1.
REQ-023: The FSM shall have three states: IDLE, MD_BUSY, MD_DONE; the down-counter cnt shall be 5 bits wide.
REQ-024: IDLE with md_op_e_i=1: md_start_o=1 for exactly one cycle, stall_f_o/stall_d_o/stall_e_o=1, flush_m_o=1, cnt<=MD_LAT-1, next state MD_BUSY.
REQ-025: MD_BUSY: stall_f_o/stall_d_o/stall_e_o=1, flush_m_o=1, md_busy_o=1; if cnt==0 next state MD_DONE, else cnt<=cnt-1.
REQ-026: MD_DONE: no stall or flush from the FSM; md_op_e_i shall be ignored (same instruction still in Execute); next state IDLE.
REQ-027: Total mul/div stall cycles shall be 1+MD_LAT; the instruction advances out of Execute in the MD_DONE cycle.
REQ-028: While the FSM drives stalls (launch cycle or MD_BUSY), lu and cf shall be masked.
REQ-029: md_op_e_i=1 in IDLE together with cf or lu is illegal stimulus; the FSM path shall win.

Reset
REQ-030: While rst_i=0, all outputs shall be 0 combinationally.
REQ-031: At a rising edge with rst_i=0, state<=IDLE and cnt<=0.
REQ-032: Reset asserted in MD_BUSY shall abort the operation; after release, the block starts in IDLE with no residual stall.

Verification
REQ-033: Forwarding: rd_m=rd_w=rs1_e=5, both regwrt=1 -> fwd_a=10; rd_m=0 -> fwd_a=01; rs1_e=0 with rd_w=0 -> 00.
REQ-034: Load-use: rsltsrc_e=01, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1 for one cycle; with rd_e=0 -> all 0.
REQ-035: Flush: pcsrc_e=10 with an lu condition -> flush_d=flush_e=1, stall_f=stall_d=0; pcsrc_e=11 -> no flush.
REQ-036: Mul/div: MD_LAT=4, md_op_e=1 held -> md_start pulse at T0, stalls T0..T4, md_busy T1..T4, MD_DONE at T5 with no stall, IDLE at T6.
REQ-037: MD_LAT=1 -> stalls T0..T1, MD_DONE at T2.
REQ-038: rst_i=0 at T2 of a mul/div operation -> outputs 0 immediately, IDLE after the edge, no stall after release with md_op_e=0.
